// File: rtl/a8_bus_pkg.sv
`timescale 1ns/1ps
// Shared types for the Atari 8-bit bus capture front-end.
// A8_CAPTURE_TIMESTAMP_EN adds a per-record phi2-rise timestamp.
package a8_bus_pkg;

   localparam int unsigned A8_ADDR_W = 16;
   localparam int unsigned A8_DATA_W = 8;

   typedef enum logic [1:0] {StIdle, StHighFilt, StHighWait, StWaitLow} cap_state_t;

   typedef struct packed {
`ifdef A8_CAPTURE_TIMESTAMP_EN
      logic [31:0]          stamp;
`endif
      logic [A8_ADDR_W-1:0] addr;
      logic [A8_DATA_W-1:0] data;
      logic                 rw_n;
      logic                 halted;
      logic                 is_short;
   } a8_cycle_t;

endpackage

// File: rtl/a8_bus_capture_if.sv
`timescale 1ns/1ps
// Captured-cycle stream: valid/ready handshake plus the head record fields.
// A8_CAPTURE_TIMESTAMP_EN adds cyc_time.
interface a8_bus_capture_if;
   import a8_bus_pkg::*;

`ifdef A8_CAPTURE_TIMESTAMP_EN
   logic [31:0]          cyc_time;
`endif
   logic                 cyc_valid;
   logic                 cyc_ready;
   logic [A8_ADDR_W-1:0] cyc_addr;
   logic [A8_DATA_W-1:0] cyc_data;
   logic                 cyc_rw_n;
   logic                 cyc_halted;
   logic                 cyc_short;

   modport master (
`ifdef A8_CAPTURE_TIMESTAMP_EN
      output cyc_time,
`endif
      output cyc_valid, cyc_addr, cyc_data, cyc_rw_n, cyc_halted, cyc_short,
      input  cyc_ready
   );

   modport slave (
`ifdef A8_CAPTURE_TIMESTAMP_EN
      input  cyc_time,
`endif
      input  cyc_valid, cyc_addr, cyc_data, cyc_rw_n, cyc_halted, cyc_short,
      output cyc_ready
   );

endinterface

// File: rtl/a8_cycle_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO of captured bus cycles; a push while full is accepted
// only when a pop happens in the same cycle. Head reads as zero when empty.
module a8_cycle_fifo
   import a8_bus_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk200,
   input  logic                   rst_n,
   input  logic                   push,
   input  a8_cycle_t              push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output a8_cycle_t              head
);

   localparam int unsigned AW = $clog2(DEPTH);

   a8_cycle_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     level_q;
   logic            wr_en, rd_en;

   assign full  = (level_q == (AW+1)'(DEPTH));
   assign empty = (level_q == '0);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign level = level_q;
   assign head  = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk200) begin
      if (wr_en) mem[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk200 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (wr_en && !rd_en)      level_q <= level_q + (AW+1)'(1);
         else if (!wr_en && rd_en) level_q <= level_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/a8_bus_capture.sv
`timescale 1ns/1ps
// Synchronises the A8 bus, tracks each phi2 cycle and queues one record per cycle.
// A8_CAPTURE_TIMESTAMP_EN stamps each record with a free-running clk200 count.
module a8_bus_capture
   import a8_bus_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned MIN_HIGH     = 8,
   parameter int unsigned SAMPLE_DELAY = 48,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                        clk200,
   input  logic                        rst_n,
   input  logic                        a8_clk,
   input  logic                        a8_rw_n,
   input  logic                        a8_halt_n,
   input  logic                        a8_rst_n,
   input  logic [A8_ADDR_W-1:0]        a8_addr,
   input  logic [A8_DATA_W-1:0]        a8_data,
   input  logic                        clr_overflow,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   a8_bus_capture_if.master            cyc
);

   localparam int unsigned SW = 4 + A8_ADDR_W + A8_DATA_W;
   localparam int unsigned CW = $clog2(SAMPLE_DELAY + 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (SAMPLE_DELAY <= MIN_HIGH) begin : g_bad_delay
      $error("SAMPLE_DELAY must exceed MIN_HIGH");
   end
   if (FIFO_DEPTH < 4 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 4..256");
   end

   logic [SW-1:0]        sync_q [SYNC_STAGES];
   logic                 clk_s, rw_s, halt_s, a8_rst_s;
   logic [A8_ADDR_W-1:0] addr_s;
   logic [A8_DATA_W-1:0] data_s;

   cap_state_t           state_q;
   logic [CW-1:0]        cnt_q;
   logic                 clk_prev_q, armed_q, overflow_q;
   logic                 rise, cap, cap_short, drop;
   logic                 fifo_full, fifo_empty, fifo_pop;
   a8_cycle_t            rec, head;

   always_ff @(posedge clk200 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {a8_clk, a8_rw_n, a8_halt_n, a8_rst_n, a8_addr, a8_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign {clk_s, rw_s, halt_s, a8_rst_s, addr_s, data_s} = sync_q[SYNC_STAGES-1];

   // armed_q blocks a false rise when reset releases while phi2 is already high
   assign rise = clk_s & ~clk_prev_q & armed_q & a8_rst_s;

   always_comb begin
      cap       = 1'b0;
      cap_short = 1'b0;
      if (a8_rst_s && state_q == StHighWait) begin
         if (!clk_s) begin
            cap       = 1'b1;
            cap_short = 1'b1;
         end else if (cnt_q == CW'(SAMPLE_DELAY)) begin
            cap = 1'b1;
         end
      end
   end

   always_ff @(posedge clk200 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         clk_prev_q <= 1'b0;
         armed_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         clk_prev_q <= clk_s;
         if (a8_rst_s && !clk_s) armed_q <= 1'b1;
         overflow_q <= drop | (overflow_q & ~clr_overflow);
         if (!a8_rst_s) begin
            state_q <= StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  if (rise) begin
                     state_q <= StHighFilt;
                     cnt_q   <= '0;
                  end
               end
               StHighFilt: begin
                  if (!clk_s) begin
                     state_q <= StIdle;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                     if (cnt_q == CW'(MIN_HIGH - 1)) state_q <= StHighWait;
                  end
               end
               StHighWait: begin
                  if (!clk_s)                             state_q <= StIdle;
                  else if (cnt_q == CW'(SAMPLE_DELAY))    state_q <= StWaitLow;
                  else if (cnt_q != '1)                   cnt_q   <= cnt_q + CW'(1);
               end
               StWaitLow: begin
                  if (!clk_s) state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

`ifdef A8_CAPTURE_TIMESTAMP_EN
   logic [31:0] ts_q, rise_time_q;

   always_ff @(posedge clk200 or negedge rst_n) begin
      if (!rst_n) begin
         ts_q        <= '0;
         rise_time_q <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
         if (state_q == StIdle && rise) rise_time_q <= ts_q;
      end
   end
`endif

   always_comb begin
      rec          = '0;
      rec.addr     = addr_s;
      rec.data     = data_s;
      rec.rw_n     = rw_s;
      rec.halted   = ~halt_s;
      rec.is_short = cap_short;
`ifdef A8_CAPTURE_TIMESTAMP_EN
      rec.stamp    = rise_time_q;
`endif
   end

   assign fifo_pop = cyc.cyc_valid & cyc.cyc_ready;
   assign drop     = cap & fifo_full & ~fifo_pop;
   assign overflow = overflow_q;

   a8_cycle_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk200    (clk200),
      .rst_n     (rst_n),
      .push      (cap),
      .push_data (rec),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level),
      .head      (head)
   );

   assign cyc.cyc_valid  = ~fifo_empty;
   assign cyc.cyc_addr   = head.addr;
   assign cyc.cyc_data   = head.data;
   assign cyc.cyc_rw_n   = head.rw_n;
   assign cyc.cyc_halted = head.halted;
   assign cyc.cyc_short  = head.is_short;
`ifdef A8_CAPTURE_TIMESTAMP_EN
   assign cyc.cyc_time   = head.stamp;
`endif

endmodule
